// File: rtl/awg_if.sv
// Bus bundle for awg_player: waveform write port, playback control and DAC sample outputs.
// The gain input exists only when AWG_GAIN_EN is defined.
interface awg_if #(
    parameter int DATA_WIDTH  = 14,
    parameter int ADDR_WIDTH  = 10,
    parameter int BURST_WIDTH = 16
) ();
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [2*DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0]   length;
    logic [BURST_WIDTH-1:0]  bursts;
    logic                    arm;
    logic                    trig;
    logic                    abort;
`ifdef AWG_GAIN_EN
    logic [15:0]             gain;
`endif
    logic [DATA_WIDTH-1:0]   dac0;
    logic [DATA_WIDTH-1:0]   dac1;
    logic                    ce;
    logic                    busy;
    logic                    done;

    modport master (
`ifdef AWG_GAIN_EN
        output gain,
`endif
        output wr_en, wr_addr, wr_data, length, bursts, arm, trig, abort,
        input  dac0, dac1, ce, busy, done
    );

    modport slave (
`ifdef AWG_GAIN_EN
        input  gain,
`endif
        input  wr_en, wr_addr, wr_data, length, bursts, arm, trig, abort,
        output dac0, dac1, ce, busy, done
    );
endinterface

// File: rtl/awg_player.sv
// Two-channel arbitrary-waveform player: block-RAM waveform store streamed to the DAC stage.
// Optional feature macro AWG_GAIN_EN adds a shared Q1.15 gain stage (one extra pipeline cycle).
//
// state | meaning
// IDLE  | waiting for arm; trig ignored
// ARMED | configuration latched, waiting for trig
// PLAY  | one RAM read per cycle, wrapping at len_q, counting repetitions
module awg_player #(
    parameter int DATA_WIDTH  = 14,
    parameter int ADDR_WIDTH  = 10,
    parameter int BURST_WIDTH = 16
) (
    input logic  clk,
    input logic  rst_n,
    awg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   rd_addr, addr_nxt;
    logic [ADDR_WIDTH-1:0]   len_q, len_nxt;
    logic [BURST_WIDTH-1:0]  cnt_q, cnt_nxt;
    logic                    rd_en;

    logic [2*DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [2*DATA_WIDTH-1:0] ram_q;
    logic                    v1;
    logic                    vlast;
    logic [DATA_WIDTH-1:0]   s0, s1;
    logic                    ce_q, done_q;
    logic [DATA_WIDTH-1:0]   dac0_q, dac1_q;
    logic                    drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_addr <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            rd_addr <= addr_nxt;
            len_q   <= len_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = rd_addr;
        len_nxt   = len_q;
        cnt_nxt   = cnt_q;
        rd_en     = 1'b0;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        len_nxt   = bus.length;
                        cnt_nxt   = bus.bursts;
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (bus.trig) begin
                        state_nxt = PLAY;
                        addr_nxt  = '0;
                    end else if (bus.arm) begin
                        len_nxt = bus.length;
                        cnt_nxt = bus.bursts;
                    end
                end
                PLAY: begin
                    rd_en = 1'b1;
                    if (rd_addr == len_q) begin
                        addr_nxt = '0;
                        // cnt_q == 0 means continuous and is never decremented
                        if (cnt_q == BURST_WIDTH'(1))
                            state_nxt = IDLE;
                        else if (cnt_q != '0)
                            cnt_nxt = cnt_q - BURST_WIDTH'(1);
                    end else begin
                        addr_nxt = rd_addr + ADDR_WIDTH'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Read-first: a same-cycle write to rd_addr leaves the old word in ram_q.
    always_ff @(posedge clk) begin
        if (bus.wr_en)
            mem[bus.wr_addr] <= bus.wr_data;
        ram_q <= mem[rd_addr];
    end

`ifdef AWG_GAIN_EN
    localparam int PW = DATA_WIDTH + 16;
    localparam logic signed [PW-1:0] SAT_MAX = {{17{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{17{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                    v2;
    logic [2*DATA_WIDTH-1:0] smp2;

    function automatic logic [DATA_WIDTH-1:0] apply_gain(
        input logic [DATA_WIDTH-1:0] s,
        input logic [15:0]           g
    );
        logic signed [PW-1:0] p;
        p = {{16{s[DATA_WIDTH-1]}}, s} * {{DATA_WIDTH{g[15]}}, g};
        p = p >>> 15;
        if (p > SAT_MAX)
            return SAT_MAX[DATA_WIDTH-1:0];
        else if (p < SAT_MIN)
            return SAT_MIN[DATA_WIDTH-1:0];
        else
            return p[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            smp2 <= '0;
        end else if (bus.abort) begin
            v2   <= 1'b0;
            smp2 <= '0;
        end else begin
            v2   <= v1;
            smp2 <= ram_q;
        end
    end

    assign vlast = v2;
    assign s0    = apply_gain(smp2[DATA_WIDTH-1:0], bus.gain);
    assign s1    = apply_gain(smp2[2*DATA_WIDTH-1:DATA_WIDTH], bus.gain);
    assign drain = v1 | v2;
`else
    assign vlast = v1;
    assign s0    = ram_q[DATA_WIDTH-1:0];
    assign s1    = ram_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign drain = v1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            ce_q   <= 1'b0;
            done_q <= 1'b0;
            dac0_q <= '0;
            dac1_q <= '0;
        end else if (bus.abort) begin
            v1     <= 1'b0;
            ce_q   <= 1'b0;
            done_q <= 1'b0;
            dac0_q <= '0;
            dac1_q <= '0;
        end else begin
            v1     <= rd_en;
            ce_q   <= vlast;
            // Falling ce with nothing behind it marks the end of a finite playback.
            done_q <= ce_q & ~vlast;
            dac0_q <= vlast ? s0 : '0;
            dac1_q <= vlast ? s1 : '0;
        end
    end

    assign bus.dac0 = dac0_q;
    assign bus.dac1 = dac1_q;
    assign bus.ce   = ce_q;
    assign bus.done = done_q;
    assign bus.busy = (state != IDLE) | drain | ce_q;
endmodule

// File: tb/tb_awg_player.sv
// Scoreboard bench for awg_player: expected samples queued at stimulus, popped on every ce.
module tb_awg_player;
    localparam int DW = 14;
`ifdef AWG_GAIN_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    awg_if bus ();
    awg_player dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2*DW-1:0] shadow [0:15];
    logic [2*DW-1:0] sb [$];

    bit mon_en = 1'b0;
    int ce_cnt, first_ce, gaps, done_cnt;
    bit prev_ce, prev_done;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        ce_cnt = 0; first_ce = -1; gaps = 0; done_cnt = 0;
    endtask

`ifdef AWG_GAIN_EN
    function automatic logic [DW-1:0] gmul(input logic [DW-1:0] s);
        int v;
        v = (int'($signed(s)) * int'($signed(bus.gain))) >>> 15;
        if (v > 8191) v = 8191;
        if (v < -8192) v = -8192;
        return DW'(v);
    endfunction
`endif

    function automatic logic [2*DW-1:0] model(input logic [2*DW-1:0] e);
`ifdef AWG_GAIN_EN
        return {gmul(e[2*DW-1:DW]), gmul(e[DW-1:0])};
`else
        return e;
`endif
    endfunction

    always @(negedge clk) begin
        logic [2*DW-1:0] want;
        if (rst_n && mon_en) begin
            if (bus.ce) begin
                chk_eq("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    want = sb.pop_front();
                    chk_eq("dac_sample", {bus.dac1, bus.dac0}, want);
                end
                if (ce_cnt == 0) first_ce = cyc;
                else if (!prev_ce) gaps++;
                ce_cnt++;
            end else begin
                chk_eq("dac_idle_zero", {bus.dac1, bus.dac0}, 0);
            end
            if (bus.done) begin
                done_cnt++;
                chk_eq("done_after_ce", prev_ce, 1);
                chk_eq("done_busy_low", bus.busy, 0);
                chk_eq("done_single", prev_done, 0);
            end
            prev_ce = bus.ce;
            prev_done = bus.done;
        end
    end

    task automatic wr(input int a, input int d0, input int d1);
        bus.wr_en = 1'b1;
        bus.wr_addr = 10'(a);
        bus.wr_data = {DW'(d1), DW'(d0)};
        tick();
        bus.wr_en = 1'b0;
        shadow[a] = {DW'(d1), DW'(d0)};
    endtask

    task automatic play(input int len, input int nb, input bit disturb);
        int t0;
        clear_stats();
        if (disturb) shadow[6] = {14'h1555, 14'd100};
        for (int r = 0; r < nb; r++)
            for (int i = 0; i <= len; i++)
                sb.push_back(model(shadow[i]));
        bus.length = 10'(len);
        bus.bursts = 16'(nb);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk_eq("armed_busy", bus.busy, 1);
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        t0 = cyc;
        if (disturb) begin
            bus.wr_en = 1'b1; bus.wr_addr = 10'd6; bus.wr_data = {14'h1555, 14'd100};
            bus.arm = 1'b1; bus.trig = 1'b1; bus.length = 10'd2; bus.bursts = 16'd1;
            tick();
            bus.wr_en = 1'b0; bus.arm = 1'b0; bus.trig = 1'b0;
        end
        for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
        repeat (2) tick();
        chk_eq("ce_count", ce_cnt, nb * (len + 1));
        chk_eq("latency", first_ce - t0, LAT);
        chk_eq("ce_gaps", gaps, 0);
        chk_eq("done_seen", done_cnt, 1);
        chk_eq("sb_drained", sb.size(), 0);
        chk_eq("busy_after", bus.busy, 0);
    endtask

    initial begin
        int t0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.length = '0; bus.bursts = '0;
        bus.arm = 1'b0; bus.trig = 1'b0; bus.abort = 1'b0;
`ifdef AWG_GAIN_EN
        bus.gain = 16'h4000;
`endif
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_outputs", {bus.dac0, bus.dac1, bus.ce, bus.busy, bus.done}, 0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        for (int a = 0; a < 16; a++) wr(a, a, -a);

        clear_stats();
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        repeat (6) tick();
        chk_eq("idle_trig_ce", ce_cnt, 0);
        chk_eq("idle_trig_busy", bus.busy, 0);

        play(7, 1, 1'b0);
        play(3, 3, 1'b0);
        play(7, 2, 1'b1);
        play(0, 4, 1'b0);

        // Continuous single-sample playback, then abort together with arm.
        wr(0, 1234, -1234);
        clear_stats();
        bus.length = 10'd0; bus.bursts = 16'd0; bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 0; i < 10; i++) sb.push_back(model(shadow[0]));
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        t0 = cyc;
        while (cyc < t0 + 11) tick();
        bus.abort = 1'b1; bus.arm = 1'b1; bus.length = 10'd5; bus.bursts = 16'd1;
        tick();
        bus.abort = 1'b0; bus.arm = 1'b0;
        chk_eq("abort_ce", bus.ce, 0);
        chk_eq("abort_busy", bus.busy, 0);
        repeat (4) tick();
        chk_eq("abort_ce_count", ce_cnt, 10);
        chk_eq("abort_no_done", done_cnt, 0);
        chk_eq("abort_sb", sb.size(), 0);
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        repeat (5) tick();
        chk_eq("post_abort_trig", ce_cnt, 10);

        // Asynchronous reset in the middle of continuous playback.
        mon_en = 1'b0;
        sb.delete();
        bus.length = 10'd15; bus.bursts = 16'd0; bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0; bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        repeat (5) tick();
        #2;
        chk_eq("pre_rst_ce", bus.ce, 1);
        rst_n = 1'b0;
        #1;
        chk_eq("async_rst", {bus.dac0, bus.dac1, bus.ce, bus.busy, bus.done}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        clear_stats();
        prev_ce = 1'b0; prev_done = 1'b0;
        mon_en = 1'b1;
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
        repeat (6) tick();
        chk_eq("rst_trig_ce", ce_cnt, 0);
        chk_eq("rst_trig_busy", bus.busy, 0);

`ifdef AWG_GAIN_EN
        wr(0, 8000, -8192);
        bus.gain = 16'h4000;
        play(0, 1, 1'b0);
        bus.gain = 16'h7FFF;
        play(0, 1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
